glyph_scanner: RTL and testbench

- Reads 5x7 glyph bitmaps out of the font character ROM and serialises them into a per-pixel stream for the WS2812B frame and scroll logic.
- Takes one character code per valid/ready handshake and drives the ROM address.
- Captures the 35-bit bitmap, then emits a 7-row by (5+GAP_COLS)-column pixel frame with row/col coordinates and a last flag.
- Sits between the peripheral's text register interface and the LED pixel writer.

---
 rtl/glyph_scanner.sv | 104 ++++++++++
 tb/tb_glyph_scanner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_scanner.sv
// glyph_scanner: fetches a 5x7 glyph from the char ROM and streams it
// as a 7 x (5+GAP_COLS) pixel frame over a valid/ready handshake.
module glyph_scanner #(
  parameter int GAP_COLS     = 1,
  parameter bit COLUMN_MAJOR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [6:0]  rom_addr,
  input  logic [34:0] rom_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_on,
  output logic [2:0]  pix_row,
  output logic [2:0]  pix_col,
  output logic        pix_last,
  output logic        busy
);

  localparam logic [2:0] LAST_COL = 3'(4 + GAP_COLS);
  localparam logic [2:0] LAST_ROW = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } state_t;

  state_t      state;
  logic [34:0] bitmap;
  logic [2:0]  row;
  logic [2:0]  col;
  logic        at_last;
  logic [5:0]  idx;

  assign at_last = (row == LAST_ROW) && (col == LAST_COL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      bitmap   <= '0;
      row      <= '0;
      col      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            rom_addr <= char_in;
            state    <= FETCH;
          end
        end
        FETCH: begin
          bitmap <= rom_data;
          row    <= '0;
          col    <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (pix_ready) begin
            // counters freeze on the final pixel
            if (at_last) begin
              state <= IDLE;
            end else if (COLUMN_MAJOR) begin
              if (row == LAST_ROW) begin
                row <= '0;
                col <= col + 3'd1;
              end else begin
                row <= row + 3'd1;
              end
            end else begin
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 3'd1;
              end else begin
                col <= col + 3'd1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    idx    = 6'd34 - (6'(row) * 6'd5 + 6'(col));
    pix_on = 1'b0;
    if (state == SHIFT && col <= 3'd4) begin
      pix_on = bitmap[idx];
    end
  end

  assign pix_valid  = (state == SHIFT);
  assign char_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign pix_row    = row;
  assign pix_col    = col;
  assign pix_last   = pix_valid && at_last;

endmodule

// File: tb/tb_glyph_scanner.sv
// tb_glyph_scanner: directed glyph streams on a row-major (gap 1) and a
// column-major (gap 0) instance, with backpressure and mid-glyph reset.
module tb_glyph_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  char_in = '0;
  logic        char_valid = 1'b0;
  logic        pix_ready = 1'b0;
  logic        sel = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  logic        a_cv, a_ready, a_valid, a_on, a_last, a_busy;
  logic [6:0]  a_addr;
  logic [34:0] a_rom;
  logic [2:0]  a_row, a_col;
  logic        b_cv, b_ready, b_valid, b_on, b_last, b_busy;
  logic [6:0]  b_addr;
  logic [34:0] b_rom;
  logic [2:0]  b_row, b_col;

  assign a_cv = char_valid & ~sel;
  assign b_cv = char_valid & sel;

  function automatic logic [34:0] font(input logic [6:0] code);
    logic [34:0] g;
    g = '0;
    if (code < 7'd32) g = '1;
    else case (code)
      7'h41: g = {5'b01110, 5'b10001, 5'b10001, 5'b11111,
                  5'b10001, 5'b10001, 5'b10001};
      7'h42: g = {5'b11110, 5'b10001, 5'b10001, 5'b11110,
                  5'b10001, 5'b10001, 5'b11110};
      7'h4D: g = {5'b10001, 5'b11011, 5'b10101, 5'b10101,
                  5'b10001, 5'b10001, 5'b10001};
      7'h30: g = {5'b01110, 5'b10001, 5'b10011, 5'b10101,
                  5'b11001, 5'b10001, 5'b01110};
      default: g = '0;
    endcase
    return g;
  endfunction

  always_comb a_rom = font(a_addr);
  always_comb b_rom = font(b_addr);

  glyph_scanner #(.GAP_COLS(1), .COLUMN_MAJOR(1'b0)) u_rm (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(a_cv),
    .char_ready(a_ready), .rom_addr(a_addr), .rom_data(a_rom),
    .pix_valid(a_valid), .pix_ready(pix_ready), .pix_on(a_on),
    .pix_row(a_row), .pix_col(a_col), .pix_last(a_last), .busy(a_busy)
  );

  glyph_scanner #(.GAP_COLS(0), .COLUMN_MAJOR(1'b1)) u_cm (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(b_cv),
    .char_ready(b_ready), .rom_addr(b_addr), .rom_data(b_rom),
    .pix_valid(b_valid), .pix_ready(pix_ready), .pix_on(b_on),
    .pix_row(b_row), .pix_col(b_col), .pix_last(b_last), .busy(b_busy)
  );

  logic       s_ready, s_valid, s_on, s_last, s_busy;
  logic [6:0] s_addr;
  logic [2:0] s_row, s_col;

  assign s_ready = sel ? b_ready : a_ready;
  assign s_valid = sel ? b_valid : a_valid;
  assign s_on    = sel ? b_on    : a_on;
  assign s_last  = sel ? b_last  : a_last;
  assign s_busy  = sel ? b_busy  : a_busy;
  assign s_addr  = sel ? b_addr  : a_addr;
  assign s_row   = sel ? b_row   : a_row;
  assign s_col   = sel ? b_col   : a_col;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!s_ready && k < 100) begin
      tick();
      k++;
    end
    chk("ready_wait", s_ready, 1);
  endtask

  task automatic run_glyph(input logic [6:0] code, input logic cm,
                           input logic stall, input int abort_at,
                           output int n, output int ones,
                           output int nlast, output int lr,
                           output int lc, output int first_on);
    logic [34:0] bm;
    int w, total, t_acc, guard, er, ec, eon;
    logic pr, stalled, done;
    logic [7:0] saved;
    bm = font(code);
    w = cm ? 5 : 6;
    total = 7 * w;
    n = 0; ones = 0; nlast = 0; lr = -1; lc = -1; first_on = -1;
    sel = cm;
    pix_ready = 1'b0;
    wait_ready();
    char_in = code;
    char_valid = 1'b1;
    tick();
    t_acc = cycle;
    char_valid = 1'b0;
    chk("fetch_valid", s_valid, 0);
    chk("fetch_busy", s_busy, 1);
    chk("fetch_ready", s_ready, 0);
    chk("fetch_addr", s_addr, code);
    tick();
    chk("first_latency", s_valid, 1);
    stalled = 1'b0;
    done = 1'b0;
    saved = '0;
    guard = 0;
    while (!done && guard < 2000) begin
      guard++;
      if (!s_valid) begin
        chk("valid_drop", s_valid, 1);
        done = 1'b1;
      end else begin
        if (stalled)
          chk("stall_hold", {s_on, s_last, s_row, s_col}, saved);
        chk("shift_ready", s_ready, 0);
        if (abort_at == n) begin
          #3 rst_n = 1'b0;
          #1;
          chk("rst_valid", s_valid, 0);
          chk("rst_busy", s_busy, 0);
          chk("rst_ready", s_ready, 1);
          chk("rst_addr", s_addr, 0);
          chk("rst_last", s_last, 0);
          #2 rst_n = 1'b1;
          char_valid = 1'b0;
          pix_ready = 1'b1;
          return;
        end
        pr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_ready = pr;
        char_valid = (stall && !s_last) ? 1'($urandom_range(0, 1)) : 1'b0;
        char_in = code ^ 7'h3F;
        if (pr) begin
          if (cm) begin
            ec = n / 7; er = n % 7;
          end else begin
            er = n / w; ec = n % w;
          end
          eon = (ec < 5) ? int'(bm[34 - (5 * er + ec)]) : 0;
          chk("order_row", s_row, er);
          chk("order_col", s_col, ec);
          chk("pix_on", s_on, eon);
          chk("pix_last", s_last, (n == total - 1));
          ones += int'(s_on);
          nlast += int'(s_last);
          if (n == 0) first_on = int'(s_on);
          if (s_last) begin
            lr = int'(s_row);
            lc = int'(s_col);
            done = 1'b1;
          end
          n++;
        end
        stalled = !pr;
        saved = {s_on, s_last, s_row, s_col};
        tick();
      end
    end
    char_valid = 1'b0;
    pix_ready = 1'b1;
    if (guard >= 2000) chk("stream_end", 0, 1);
    chk("ready_return", s_ready, 1);
    chk("idle_valid", s_valid, 0);
    chk("addr_hold", s_addr, code);
    if (!stall) chk("period", cycle - t_acc, total + 1);
  endtask

  typedef struct {
    logic [6:0] code;
    logic       cm;
    logic       stall;
    int         n;
    int         ones;
    int         lr;
    int         lc;
    int         first_on;
  } vec_t;

  vec_t tv[6];

  initial begin
    int n, ones, nlast, lr, lc, fo;
    tv[0] = '{7'h41, 1'b0, 1'b0, 42, 18, 6, 5, 0};
    tv[1] = '{7'h05, 1'b0, 1'b0, 42, 35, 6, 5, 1};
    tv[2] = '{7'h4D, 1'b0, 1'b1, 42, 18, 6, 5, 1};
    tv[3] = '{7'h30, 1'b1, 1'b0, 35, 19, 6, 4, 0};
    tv[4] = '{7'h42, 1'b1, 1'b1, 35, 20, 6, 4, 1};
    tv[5] = '{7'h20, 1'b0, 1'b0, 42,  0, 6, 5, 0};

    repeat (3) tick();
    chk("por_valid", a_valid, 0);
    chk("por_busy", a_busy, 0);
    chk("por_ready", a_ready, 1);
    chk("por_addr", a_addr, 0);
    chk("por_on", a_on, 0);
    chk("por_last", a_last, 0);
    chk("por_cm_ready", b_ready, 1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_glyph(tv[i].code, tv[i].cm, tv[i].stall, -1,
                n, ones, nlast, lr, lc, fo);
      chk("tbl_count", n, tv[i].n);
      chk("tbl_ones", ones, tv[i].ones);
      chk("tbl_nlast", nlast, 1);
      chk("tbl_last_row", lr, tv[i].lr);
      chk("tbl_last_col", lc, tv[i].lc);
      chk("tbl_first_on", fo, tv[i].first_on);
    end

    run_glyph(7'h4D, 1'b0, 1'b0, 9, n, ones, nlast, lr, lc, fo);
    chk("abort_count", n, 9);
    tick();
    chk("abort_ready", a_ready, 1);
    chk("abort_valid", a_valid, 0);
    run_glyph(7'h42, 1'b0, 1'b0, -1, n, ones, nlast, lr, lc, fo);
    chk("after_rst_count", n, 42);
    chk("after_rst_ones", ones, 20);
    chk("after_rst_first", fo, 1);
    chk("after_rst_last_col", lc, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
